// File: rtl/ram_lsu_port.sv
// Load/store port in front of the single-port data SRAM: byte/half/word access,
// word addressing with byte write masks, and a registered load-data response.
module ram_lsu_port #(
  parameter int AW = 32,
  parameter int DP = 512
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_uns,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [3:0]    ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] RSP     = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;

  logic [AW-1:0] word_idx;
  logic          misalign;
  logic          illegal;
  logic          accept;
  logic          accept_ok;
  logic [31:0]   load_fmt;

  // Right-align the addressed byte/half of the SRAM word, then extend.
  function automatic logic [31:0] fmt_load(input logic [1:0]  sz,
                                           input logic        uns,
                                           input logic [1:0]  off,
                                           input logic [31:0] dout);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = dout[8*off +: 8];
    h = off[1] ? dout[31:16] : dout[15:0];
    case (sz)
      SZ_B:    r = {{24{~uns & b[7]}}, b};
      SZ_H:    r = {{16{~uns & h[15]}}, h};
      default: r = dout;
    endcase
    return r;
  endfunction

  always_comb begin
    word_idx  = req_addr >> 2;
    misalign  = ((req_size == SZ_H) && req_addr[0]) ||
                ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    illegal   = (req_size == 2'd3) || misalign || (word_idx >= AW'(DP));
    // Ready is gated by reset so nothing reaches the SRAM while held in reset.
    req_rdy   = rstn && (state_q == IDLE);
    accept    = req_vld && req_rdy;
    accept_ok = accept && !illegal;
    load_fmt  = fmt_load(size_q, uns_q, off_q, ram_dout);
  end

  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_wem  = 4'b0000;
    ram_addr = '0;
    ram_din  = 32'h0;
    if (accept_ok) begin
      ram_cs   = 1'b1;
      ram_addr = word_idx;
      if (req_we) begin
        ram_we = 1'b1;
        case (req_size)
          SZ_B: begin
            ram_wem = 4'b0001 << req_addr[1:0];
            ram_din = {4{req_wdata[7:0]}};
          end
          SZ_H: begin
            ram_wem = 4'b0011 << req_addr[1:0];
            ram_din = {2{req_wdata[15:0]}};
          end
          default: begin
            ram_wem = 4'b1111;
            ram_din = req_wdata;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rsp_vld_d   = rsp_vld_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal || req_we) begin
            state_d     = RSP;
            rsp_vld_d   = 1'b1;
            rsp_err_d   = illegal;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d = RD_WAIT;
            size_d  = req_size;
            uns_d   = req_uns;
            off_d   = req_addr[1:0];
          end
        end
      end
      RD_WAIT: begin
        state_d     = RSP;
        rsp_vld_d   = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = load_fmt;
      end
      RSP: begin
        if (rsp_rdy) begin
          state_d   = IDLE;
          rsp_vld_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        rsp_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
    end
  end

  assign rsp_vld   = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ram_lsu_port.sv
// Directed bench for ram_lsu_port with a behavioural registered-read SRAM.
module tb_ram_lsu_port;

  logic        clk;
  logic        rstn;
  logic        req_vld;
  logic        req_rdy;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_uns;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_cs;
  logic        ram_we;
  logic [3:0]  ram_wem;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:511];

  ram_lsu_port #(.AW(32), .DP(512)) dut (
    .clk(clk), .rstn(rstn),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
    .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // SRAM model: byte-masked write, registered-address read.
  always @(posedge clk) begin
    if (ram_cs) begin
      chk("ram_range", {31'd0, ram_addr < 32'd512}, 32'd1);
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) mem[ram_addr[8:0]][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_addr[8:0]];
      end
    end
  end

  // One request: checks the SRAM strobes in the accept cycle, then latency and response.
  task automatic req(input string tag, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic exp_cs, input logic [3:0] exp_wem, input logic [31:0] exp_din,
                     input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
    int lat;
    req_vld = 1'b1; req_we = we; req_size = sz; req_uns = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    chk({tag, ".rdy"},  {31'd0, req_rdy}, 32'd1);
    chk({tag, ".cs"},   {31'd0, ram_cs}, {31'd0, exp_cs});
    chk({tag, ".we"},   {31'd0, ram_we}, {31'd0, exp_cs & we});
    chk({tag, ".wem"},  {28'd0, ram_wem}, {28'd0, exp_wem});
    chk({tag, ".addr"}, ram_addr, exp_cs ? (addr >> 2) : 32'd0);
    chk({tag, ".din"},  ram_din, exp_din);
    @(posedge clk); #1;
    req_vld = 1'b0;
    lat = 1;
    while (!rsp_vld && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"},  lat, exp_lat);
    chk({tag, ".err"},  {31'd0, rsp_err}, {31'd0, exp_err});
    chk({tag, ".data"}, rsp_rdata, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    ram_dout = 32'h0;
    rstn = 1'b0; rsp_rdy = 1'b1;
    req_vld = 1'b1; req_we = 1'b1; req_size = 2'd2; req_uns = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h1234_5678;
    #12;
    chk("rst.rdy",   {31'd0, req_rdy}, 32'd0);
    chk("rst.cs",    {31'd0, ram_cs}, 32'd0);
    chk("rst.vld",   {31'd0, rsp_vld}, 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    chk("rst.err",   {31'd0, rsp_err}, 32'd0);
    req_vld = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Word store/load
    req("stw", 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 1, 4'hF, 32'hDEAD_BEEF, 1, 0, 32'h0);
    req("ldw", 0, 2'd2, 0, 32'h10, 32'h0,         1, 4'h0, 32'h0,         2, 0, 32'hDEAD_BEEF);
    // Byte store into top lane, signed/unsigned reload, neighbours untouched
    req("stb", 1, 2'd0, 0, 32'h13, 32'h0000_0080, 1, 4'b1000, 32'h8080_8080, 1, 0, 32'h0);
    req("ldbs", 0, 2'd0, 0, 32'h13, 32'h0,        1, 4'h0, 32'h0,         2, 0, 32'hFFFF_FF80);
    req("ldbu", 0, 2'd0, 1, 32'h13, 32'h0,        1, 4'h0, 32'h0,         2, 0, 32'h0000_0080);
    req("ldw2", 0, 2'd2, 0, 32'h10, 32'h0,        1, 4'h0, 32'h0,         2, 0, 32'h80AD_BEEF);
    req("ldb1", 0, 2'd0, 0, 32'h11, 32'h0,        1, 4'h0, 32'h0,         2, 0, 32'hFFFF_FFBE);
    // Upper half store/load
    req("sth", 1, 2'd1, 0, 32'h22, 32'hAAAA_8001, 1, 4'b1100, 32'h8001_8001, 1, 0, 32'h0);
    req("ldhs", 0, 2'd1, 0, 32'h22, 32'h0,        1, 4'h0, 32'h0,         2, 0, 32'hFFFF_8001);
    req("ldhl", 0, 2'd1, 1, 32'h10, 32'h0,        1, 4'h0, 32'h0,         2, 0, 32'h0000_BEEF);
    // Illegal requests never reach the SRAM
    req("mis_w", 0, 2'd2, 0, 32'h02, 32'h0,  0, 4'h0, 32'h0, 1, 1, 32'h0);
    req("mis_h", 0, 2'd1, 0, 32'h05, 32'h0,  0, 4'h0, 32'h0, 1, 1, 32'h0);
    req("sz3",   0, 2'd3, 0, 32'h00, 32'h0,  0, 4'h0, 32'h0, 1, 1, 32'h0);
    req("oor",   0, 2'd2, 0, 32'h800, 32'h0, 0, 4'h0, 32'h0, 1, 1, 32'h0);
    req("oor_st", 1, 2'd2, 0, 32'h800, 32'hFFFF_FFFF, 0, 4'h0, 32'h0, 1, 1, 32'h0);
    req("ldlast", 0, 2'd2, 0, 32'h7FC, 32'h0, 1, 4'h0, 32'h0, 2, 0, 32'h0);

    // Response held while rsp_rdy low
    rsp_rdy = 1'b0;
    req("hold", 0, 2'd2, 0, 32'h10, 32'h0, 1, 4'h0, 32'h0, 2, 0, 32'h80AD_BEEF);
    for (int i = 0; i < 4; i++) begin
      chk("hold.vld",  {31'd0, rsp_vld}, 32'd1);
      chk("hold.data", rsp_rdata, 32'h80AD_BEEF);
      chk("hold.rdy",  {31'd0, req_rdy}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    chk("rel.vld", {31'd0, rsp_vld}, 32'd0);
    chk("rel.rdy", {31'd0, req_rdy}, 32'd1);
    req("b2b", 0, 2'd1, 1, 32'h22, 32'h0, 1, 4'h0, 32'h0, 2, 0, 32'h0000_8001);

    // Reset pulse while the load sits in RD_WAIT
    req_vld = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
    @(posedge clk); #1;
    req_vld = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rrd.vld", {31'd0, rsp_vld}, 32'd0);
    chk("rrd.rdy", {31'd0, req_rdy}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    chk("rrd.rdy_rel", {31'd0, req_rdy}, 32'd1);
    @(posedge clk); #1;
    chk("rrd.vld2", {31'd0, rsp_vld}, 32'd0);
    req("post", 0, 2'd2, 0, 32'h20, 32'h0, 1, 4'h0, 32'h0, 2, 0, 32'h8001_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
